lane_merge_mux: RTL

//  Downstream recombiner for the 1:2 lane demux stage. Accepts the two demuxed lanes
//  (lane 0, lane 1), buffers each in a small FIFO, and merges them back into one

---
 rtl/lane_merge_pkg.sv | 26 ++
 rtl/lane_fifo.sv | 88 ++++++++
 rtl/lane_merge_mux.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/lane_merge_pkg.sv
`default_nettype none
// ============================================================================
// Package   : lane_merge_pkg
// Purpose   : Shared types and defaults for the lane merge stage.
//             lane_t encodes the round-robin turn. lane_merge_cnt_width()
//             sizes FIFO occupancy counters so they can represent DEPTH.
// Revision  : 1.0 - initial release
// ============================================================================
package lane_merge_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [0:0] {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_t;

  // One extra bit over the pointer width so a completely full FIFO
  // (count == DEPTH) remains representable.
  function automatic int lane_merge_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : lane_merge_pkg
`default_nettype wire

// File: rtl/lane_fifo.sv
`default_nettype none
// ============================================================================
// Module    : lane_fifo
// Purpose   : Single-clock FIFO buffering one demuxed lane.
//             The head word is presented combinationally on data_out.
//             A push on a full FIFO is accepted only when the same edge
//             also pops; otherwise it is silently ignored (the caller
//             flags the drop).
// Ports     : clk      - rising-edge clock
//             reset    - synchronous active-high reset (empties the FIFO)
//             push     - write data_in this edge
//             pop      - remove the head word this edge (ignored if empty)
//             data_in  - word to write
//             data_out - head word (valid while !empty)
//             full     - FIFO holds DEPTH words
//             empty    - FIFO holds no words
//             count    - current occupancy
// Revision  : 1.0 - initial release
// ============================================================================
module lane_fifo
  import lane_merge_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    push,
  input  logic                                    pop,
  input  logic [WIDTH-1:0]                        data_in,
  output logic [WIDTH-1:0]                        data_out,
  output logic                                    full,
  output logic                                    empty,
  output logic [lane_merge_cnt_width(DEPTH)-1:0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = lane_merge_cnt_width(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);
  assign count = r_count;

  // A full FIFO can still take a word when the head leaves on the same edge.
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  assign data_out = r_mem[r_rd_ptr];

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : lane_fifo
`default_nettype wire

// File: rtl/lane_merge_mux.sv
`default_nettype none
// ============================================================================
// Module    : lane_merge_mux
// Purpose   : Recombines the two lanes of a 1:2 demux into one stream.
//             Each lane is buffered in a lane_fifo; a work-conserving
//             round-robin arbiter feeds a registered valid/ready output.
// Ports     : clk        - rising-edge clock
//             reset      - synchronous active-high reset
//             data_in0   - lane 0 word,  valid_in0 - lane 0 word present
//             data_in1   - lane 1 word,  valid_in1 - lane 1 word present
//             ready_in   - downstream accepts data_out this cycle
//             data_out   - merged word,  valid_out - data_out holds a word
//             full0/1    - lane FIFO holds DEPTH words
//             overflow   - sticky: a word was dropped on a full FIFO
//             parity_out - ^data_out, registered with it
//                          (only when LANE_MERGE_PARITY_EN is defined)
// Config    : LANE_MERGE_PARITY_EN - adds the parity_out port and logic.
// Revision  : 1.0 - initial release
// ============================================================================
module lane_merge_mux
  import lane_merge_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in0,
  input  logic             valid_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic             valid_in1,
  input  logic             ready_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             full0,
  output logic             full1,
`ifdef LANE_MERGE_PARITY_EN
  output logic             parity_out,
`endif
  output logic             overflow
);

  localparam int CW = lane_merge_cnt_width(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  lane_t            r_turn;
  logic [WIDTH-1:0] r_data_out;
  logic             r_valid_out;
  logic             r_overflow;

  logic [WIDTH-1:0] w_head0;
  logic [WIDTH-1:0] w_head1;
  logic             w_fifo_full0;
  logic             w_fifo_full1;
  logic             w_empty0;
  logic             w_empty1;
  logic [CW-1:0]    w_count0;
  logic [CW-1:0]    w_count1;

  logic             w_load;
  logic             w_pick0;
  logic             w_pick1;
  logic             w_drop;

  // --------------------------------------------------------------------------
  // Lane buffers
  // --------------------------------------------------------------------------
  lane_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk      (clk),
    .reset    (reset),
    .push     (valid_in0),
    .pop      (w_pick0),
    .data_in  (data_in0),
    .data_out (w_head0),
    .full     (w_fifo_full0),
    .empty    (w_empty0),
    .count    (w_count0)
  );

  lane_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk      (clk),
    .reset    (reset),
    .push     (valid_in1),
    .pop      (w_pick1),
    .data_in  (data_in1),
    .data_out (w_head1),
    .full     (w_fifo_full1),
    .empty    (w_empty1),
    .count    (w_count1)
  );

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  // The output register can take a new word when it is empty or being drained.
  assign w_load = !r_valid_out || ready_in;

  // Turn's lane wins if it has data; otherwise fall through to the other lane
  // so a single active lane is never starved by an idle one.
  assign w_pick0 = w_load && !w_empty0 && ((r_turn == LANE0) || w_empty1);
  assign w_pick1 = w_load && !w_empty1 && ((r_turn == LANE1) || w_empty0);

  // A push is lost only when the FIFO is full and is not popped this edge.
  assign w_drop = (valid_in0 && w_fifo_full0 && !w_pick0) ||
                  (valid_in1 && w_fifo_full1 && !w_pick1);

  // --------------------------------------------------------------------------
  // Turn state, output register and sticky overflow
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_turn      <= LANE0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_pick0) begin
        r_data_out  <= w_head0;
        r_valid_out <= 1'b1;
        r_turn      <= LANE1;
      end else if (w_pick1) begin
        r_data_out  <= w_head1;
        r_valid_out <= 1'b1;
        r_turn      <= LANE0;
      end else if (w_load) begin
        // Nothing to send: drop valid, keep the last word and the turn.
        r_valid_out <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef LANE_MERGE_PARITY_EN
  logic r_parity;

  // Parity is captured from the same head word that loads data_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_pick0) begin
      r_parity <= ^w_head0;
    end else if (w_pick1) begin
      r_parity <= ^w_head1;
    end
  end

  assign parity_out = r_parity;
`endif

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign overflow  = r_overflow;
  assign full0     = (w_count0 == C_DEPTH);
  assign full1     = (w_count1 == C_DEPTH);

endmodule : lane_merge_mux
`default_nettype wire
